vga_rect_fill: RTL

Rectangle-fill drawing engine that sits directly upstream of the VGA adapter's video-memory write port. On a start strobe it latches a rectangle (origin, size, colour) and emits one pixel write per clock on `x`/`y`/`colour_out`/`plot`, in raster order. The rectangle is clipped to the adapter's dot resolution. It is used for screen clears, sprites and background blocks, and shares RESOLUTION and colour-depth parameters with the adapter.

---
 rtl/vga_rect_fill.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine for the VGA adapter write port: latches a clipped
// rectangle on start and emits one raster-ordered pixel write per clock.
module vga_rect_fill #(
    parameter string RESOLUTION              = "320x240",
    parameter int    BITS_PER_COLOUR_CHANNEL = 1,
    parameter string MONOCHROME              = "FALSE",
    localparam int   XW = (RESOLUTION == "160x120") ? 8 : 9,
    localparam int   YW = (RESOLUTION == "160x120") ? 7 : 8,
    localparam int   CW = (MONOCHROME == "TRUE") ? 1 : 3 * BITS_PER_COLOUR_CHANNEL
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    input  logic [CW-1:0] colour,
    input  logic          abort,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour_out,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam int XMAX = (RESOLUTION == "160x120") ? 160 : 320;
    localparam int YMAX = (RESOLUTION == "160x120") ? 120 : 240;
    localparam logic [XW:0]   X_LIM = XMAX[XW:0];
    localparam logic [YW:0]   Y_LIM = YMAX[YW:0];
    localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [YW-1:0] Y_ONE = {{(YW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x0_q, x0_d;
    logic [XW-1:0] xe_q, xe_d;
    logic [YW-1:0] ye_q, ye_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] colour_out_q, colour_out_d;
    logic          plot_q, plot_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [XW:0]   xsum_s;
    logic [YW:0]   ysum_s;
    logic [XW-1:0] xe_s;
    logic [YW-1:0] ye_s;
    logic          empty_s;

    // Clip the requested extent to the screen; sums carry one extra bit so they never wrap.
    always_comb begin
        xsum_s  = {1'b0, x0} + {1'b0, w};
        ysum_s  = {1'b0, y0} + {1'b0, h};
        xe_s    = (xsum_s > X_LIM) ? X_LIM[XW-1:0] : xsum_s[XW-1:0];
        ye_s    = (ysum_s > Y_LIM) ? Y_LIM[YW-1:0] : ysum_s[YW-1:0];
        empty_s = (w == {XW{1'b0}}) || (h == {YW{1'b0}}) ||
                  ({1'b0, x0} >= X_LIM) || ({1'b0, y0} >= Y_LIM);
    end

    // Next-state and raster-walk logic; x/y double as the walking cursor and hold outside DRAW.
    always_comb begin
        state_d      = state_q;
        x0_d         = x0_q;
        xe_d         = xe_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_out_d = colour_out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (empty_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d      = S_DRAW;
                        x0_d         = x0;
                        xe_d         = xe_s;
                        ye_d         = ye_s;
                        x_d          = x0;
                        y_d          = y0;
                        colour_out_d = colour;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                if (abort) begin
                    state_d = S_DONE;
                end else if (x_q == xe_q - X_ONE) begin
                    if (y_q == ye_q - Y_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        x_d = x0_q;
                        y_d = y_q + Y_ONE;
                    end
                end else begin
                    x_d = x_q + X_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        plot_d = (state_d == S_DRAW);
        busy_d = (state_d == S_DRAW);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            x0_q         <= {XW{1'b0}};
            xe_q         <= {XW{1'b0}};
            ye_q         <= {YW{1'b0}};
            x_q          <= {XW{1'b0}};
            y_q          <= {YW{1'b0}};
            colour_out_q <= {CW{1'b0}};
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x0_q         <= x0_d;
            xe_q         <= xe_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_out_q <= colour_out_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour_out = colour_out_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
